// File: rtl/decoder_pkg.sv
// Shared constants and reference helper for the 4-to-16 one-hot decoder.
// onehot16 is the behavioural form of the decode, handy wherever a quick model is needed.
package decoder_pkg;

  localparam int IN_W  = 4;
  localparam int OUT_W = 2 ** IN_W;

  function automatic logic [OUT_W-1:0] onehot16(input logic [IN_W-1:0] sel);
    onehot16 = OUT_W'(1) << sel;
  endfunction

endpackage

// File: rtl/decoder_4to16_core.sv
// Purely combinational 4-to-16 decode built from AND terms of true/complemented select bits.
// Every select code maps to exactly one set bit; there are no invalid codes.
module decoder_4to16_core
  import decoder_pkg::*;
(
  output logic [OUT_W-1:0] onehot,
  input  logic [IN_W-1:0]  sel
);

  assign onehot[0]  = ~sel[3] & ~sel[2] & ~sel[1] & ~sel[0];
  assign onehot[1]  = ~sel[3] & ~sel[2] & ~sel[1] &  sel[0];
  assign onehot[2]  = ~sel[3] & ~sel[2] &  sel[1] & ~sel[0];
  assign onehot[3]  = ~sel[3] & ~sel[2] &  sel[1] &  sel[0];
  assign onehot[4]  = ~sel[3] &  sel[2] & ~sel[1] & ~sel[0];
  assign onehot[5]  = ~sel[3] &  sel[2] & ~sel[1] &  sel[0];
  assign onehot[6]  = ~sel[3] &  sel[2] &  sel[1] & ~sel[0];
  assign onehot[7]  = ~sel[3] &  sel[2] &  sel[1] &  sel[0];
  assign onehot[8]  =  sel[3] & ~sel[2] & ~sel[1] & ~sel[0];
  assign onehot[9]  =  sel[3] & ~sel[2] & ~sel[1] &  sel[0];
  assign onehot[10] =  sel[3] & ~sel[2] &  sel[1] & ~sel[0];
  assign onehot[11] =  sel[3] & ~sel[2] &  sel[1] &  sel[0];
  assign onehot[12] =  sel[3] &  sel[2] & ~sel[1] & ~sel[0];
  assign onehot[13] =  sel[3] &  sel[2] & ~sel[1] &  sel[0];
  assign onehot[14] =  sel[3] &  sel[2] &  sel[1] & ~sel[0];
  assign onehot[15] =  sel[3] &  sel[2] &  sel[1] &  sel[0];

endmodule

// File: rtl/decoder_4to16_df.sv
// Registered 4-to-16 decoder: combinational core, polarity select, then output registers.
// valid is a plain qualifier (no ready): valid=1 means d holds the decode of i sampled with en=1 one clock earlier.
module decoder_4to16_df
  import decoder_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  output logic [OUT_W-1:0] d,
  input  logic [IN_W-1:0]  i,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             valid
);

  logic [OUT_W-1:0] onehot;
  logic [OUT_W-1:0] decoded;

  decoder_4to16_core u_core (
    .onehot (onehot),
    .sel    (i)
  );

  // Polarity only affects enabled decodes; idle and reset outputs stay all-zero.
  always_comb begin
    decoded = onehot;
    if (ACTIVE_LOW) decoded = ~onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d     <= '0;
      valid <= 1'b0;
    end else if (en) begin
      d     <= decoded;
      valid <= 1'b1;
    end else begin
      d     <= '0;
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decoder_4to16_df.sv
// Bench for decoder_4to16_df: directed steps plus random traffic, one-hot and one-cold instances
// driven in parallel and checked against an arithmetic model through an expected queue.
module tb_decoder_4to16_df;

  logic [15:0] d_hi, d_lo;
  logic        valid_hi, valid_lo;
  logic [3:0]  i;
  logic        clk, rst, en;

  // Expected entry packing: {valid, d one-cold, d one-hot}
  logic [32:0] exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  decoder_4to16_df #(.ACTIVE_LOW(1'b0)) dut_hi (
    .d(d_hi), .i(i), .clk(clk), .rst(rst), .en(en), .valid(valid_hi)
  );

  decoder_4to16_df #(.ACTIVE_LOW(1'b1)) dut_lo (
    .d(d_lo), .i(i), .clk(clk), .rst(rst), .en(en), .valid(valid_lo)
  );

  // Clock and initial input values
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    en  = 1'b0;
    i   = 4'h0;
  end
  always #5 clk = ~clk;

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Model: selected bit index equals the select value, computed as a power of two.
  task automatic step(input string tag, input logic rst_v, input logic en_v, input logic [3:0] i_v);
    logic [15:0] hot;
    logic [32:0] exp_e;
    logic        v;
    rst = rst_v;
    en  = en_v;
    i   = i_v;
    hot = 16'(2 ** int'(i_v));
    v   = !rst_v && en_v;
    exp_e = v ? {1'b1, ~hot, hot} : 33'h0;
    exp_q.push_back(exp_e);
    @(posedge clk);
    #1;
    exp_e = exp_q.pop_front();
    check16({tag, "_d"},       d_hi,     exp_e[15:0]);
    check1 ({tag, "_valid"},   valid_hi, exp_e[32]);
    check16({tag, "_d_al"},    d_lo,     exp_e[31:16]);
    check1 ({tag, "_valid_al"}, valid_lo, exp_e[32]);
    if (exp_e[32]) begin
      n_assert++;
      assert ($countones(d_hi) == 1) else begin
        n_fail++;
        $error("FAIL %s_popcount: observed %0d expected 1", tag, $countones(d_hi));
      end
    end
  endtask

  initial begin
    // Reset held with en=1, i=A
    for (int k = 0; k < 3; k++) step("reset", 1'b1, 1'b1, 4'hA);
    step("reset_release", 1'b0, 1'b1, 4'hA);

    // Full sweep including 0 and 15 boundaries
    for (int k = 0; k < 16; k++) step("sweep", 1'b0, 1'b1, 4'(k));

    // Enable gating
    step("en_on",  1'b0, 1'b1, 4'h3);
    step("en_off", 1'b0, 1'b0, 4'h3);
    step("en_on2", 1'b0, 1'b1, 4'h3);

    // Polarity corners (checked on the one-cold instance too)
    step("pol_0",   1'b0, 1'b1, 4'h0);
    step("pol_f",   1'b0, 1'b1, 4'hF);
    step("pol_off", 1'b0, 1'b0, 4'hF);

    // Reset mid-stream
    for (int k = 0; k < 8; k++) step("mid_sweep", 1'b0, 1'b1, 4'(k));
    step("mid_rst",   1'b1, 1'b1, 4'h8);
    step("mid_after", 1'b0, 1'b1, 4'h9);

    // Random traffic with occasional reset
    for (int k = 0; k < 1000; k++)
      step("random", ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
